// File: rtl/snake_pkg.sv
// Direction encoding shared by the key front end and the game controller.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_RIGHT = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  // Opposite directions differ only in bit 0 (up/down, right/left).
  function automatic dir_t dir_opposite(input dir_t d);
    return d ^ 2'd1;
  endfunction

  // A turn is meaningful only if it neither repeats nor reverses the reference heading.
  function automatic logic turn_ok(input dir_t cand, input dir_t ref_dir);
    return (cand != ref_dir) && (cand != dir_opposite(ref_dir));
  endfunction

endpackage

// File: rtl/dir_input_unit_if.sv
// Key/step inputs and direction-stream outputs of dir_input_unit; master = game side, slave = the unit.
interface dir_input_unit_if
  import snake_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int QUEUE_DEPTH = 4
);

  logic [N_KEYS-1:0]              key_in;
  logic                           step;
  logic [N_KEYS-1:0]              key_pulse;
  dir_t                           dir;
  logic                           dir_change;
  logic [$clog2(QUEUE_DEPTH):0]   q_level;
  logic                           q_overflow;

  modport master (
    output key_in, step,
    input  key_pulse, dir, dir_change, q_level, q_overflow
  );

  modport slave (
    input  key_in, step,
    output key_pulse, dir, dir_change, q_level, q_overflow
  );

endinterface

// File: rtl/dir_input_unit_key_debounce.sv
// One key channel: optional 2-FF synchroniser (KEY_SYNC_EN), stability counter, press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20,
  parameter bit KEY_ACT_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             pressed;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             pulse_q;

`ifdef KEY_SYNC_EN
  logic [1:0] sync_q;

  // Synchroniser resets to the released level so a reset never fakes a press.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) sync_q <= {2{KEY_ACT_LOW}};
    else         sync_q <= {sync_q[0], key_i};
  end

  assign pressed = sync_q[1] ^ KEY_ACT_LOW;
`else
  assign pressed = key_i ^ KEY_ACT_LOW;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (pressed == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = pressed;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/dir_input_unit.sv
// Snake key front end: debounced key pulses, reversal/repeat filter, turn queue popped by step.
// Optional KEY_SYNC_EN macro adds a 2-FF synchroniser per key ahead of debounce.
module dir_input_unit
  import snake_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20,
  parameter bit KEY_ACT_LOW  = 1'b1,
  parameter int QUEUE_DEPTH  = 4
) (
  input logic             clk,
  input logic             rstn,
  dir_input_unit_if.slave bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [N_KEYS-1:0] pulse;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W),
      .KEY_ACT_LOW  (KEY_ACT_LOW)
    ) u_deb (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .key_i   (bus.key_in[i]),
      .pulse_o (pulse[i])
    );
  end

  dir_t             mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [LVL_W-1:0] level_q, level_d;
  dir_t             dir_q, dir_d;
  logic             pop_q, chg_q, ovf_q;

  dir_t cand, ref_dir;
  logic cand_vld, empty, full, pop, accept, push, drop;

  // Lowest-index direction key wins; simultaneous losers are discarded.
  always_comb begin
    cand_vld = |pulse[3:0];
    cand     = DIR_UP;
    if      (pulse[0]) cand = DIR_UP;
    else if (pulse[1]) cand = DIR_DOWN;
    else if (pulse[2]) cand = DIR_RIGHT;
    else if (pulse[3]) cand = DIR_LEFT;
  end

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LVL_W'(QUEUE_DEPTH));
    ref_dir = empty ? dir_q : mem_q[tail_q - PTR_W'(1)];
    pop     = bus.step && !empty;
    accept  = cand_vld && turn_ok(cand, ref_dir);
    // A pop in the same cycle frees the slot a full queue would otherwise lack.
    push    = accept && (!full || pop);
    drop    = accept && full && !pop;
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    dir_d   = pop ? mem_q[head_q] : dir_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= cand;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      dir_q   <= DIR_RIGHT;
      pop_q   <= 1'b0;
      chg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      pop_q   <= pop;
      chg_q   <= pop_q;
      ovf_q   <= drop;
    end
  end

  assign bus.key_pulse  = pulse;
  assign bus.dir        = dir_q;
  assign bus.dir_change = chg_q;
  assign bus.q_level    = level_q;
  assign bus.q_overflow = ovf_q;

endmodule

// File: tb/tb_dir_input_unit.sv
// Bench for dir_input_unit: directed table, corner sequences, and random traffic against a queue-level model.
module tb_dir_input_unit;
  import snake_pkg::*;

  localparam int NK = 5;
  localparam int D  = 8;
  localparam int CW = 4;
  localparam int QD = 4;
`ifdef KEY_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dir_input_unit_if #(.N_KEYS(NK), .QUEUE_DEPTH(QD)) bus ();

  dir_input_unit #(
    .N_KEYS(NK), .DEBOUNCE_CYC(D), .CNT_W(CW), .KEY_ACT_LOW(1'b1), .QUEUE_DEPTH(QD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: stable level flips once D consecutive samples since the last
  // agreement disagree with it; the turn queue is a plain SV queue.
  int          cyc = 0;
  int          idx = 0;
  bit          chk_en = 0;
  bit [NK-1:0] m_stable, m_rose, m_pulse;
  int          last_same [NK];
  dir_t        m_q [$];
  dir_t        m_dir;
  bit          m_pop_prev, m_chg, m_ovf;
`ifdef KEY_SYNC_EN
  bit [NK-1:0] m_s1, m_s2;
`endif

  int ovf_cnt = 0;
  int chg_cnt = 0;
  int pcnt  [NK];
  int plast [NK];

  task automatic model_reset();
    m_stable   = '0;
    m_rose     = '0;
    m_pulse    = '0;
    for (int k = 0; k < NK; k++) last_same[k] = idx;
    m_q.delete();
    m_dir      = DIR_RIGHT;
    m_pop_prev = 0;
    m_chg      = 0;
    m_ovf      = 0;
`ifdef KEY_SYNC_EN
    m_s1 = '0;
    m_s2 = '0;
`endif
  endtask

  task automatic model_step();
    bit          valid, pop, accept, full_before;
    dir_t        cand, rf;
    bit [NK-1:0] samp;
    idx++;
    if (!rstn) begin
      model_reset();
      chk_en = 1;
      return;
    end
    m_chg = m_pop_prev;
    valid = 0;
    cand  = DIR_UP;
    for (int k = 3; k >= 0; k--) if (m_pulse[k]) begin valid = 1; cand = dir_t'(k); end
    pop         = bus.step && (m_q.size() > 0);
    rf          = (m_q.size() > 0) ? m_q[$] : m_dir;
    accept      = valid && (cand != rf) && (cand != (rf ^ 2'd1));
    full_before = (m_q.size() == QD);
    if (pop) m_dir = m_q.pop_front();
    m_ovf = 0;
    if (accept) begin
      if (!full_before || pop) m_q.push_back(cand);
      else m_ovf = 1;
    end
    m_pop_prev = pop;

`ifdef KEY_SYNC_EN
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = ~bus.key_in;
`else
    samp = ~bus.key_in;
`endif
    m_pulse = m_rose;
    m_rose  = '0;
    for (int k = 0; k < NK; k++) begin
      if (samp[k] == m_stable[k]) last_same[k] = idx;
      else if (idx - last_same[k] >= D) begin
        m_stable[k]  = samp[k];
        last_same[k] = idx;
        m_rose[k]    = samp[k];
      end
    end
  endtask

  // Inputs change at negedge+1, so at the negedge they still hold what the last posedge sampled.
  always @(negedge clk) begin
    cyc++;
    model_step();
    if (chk_en) begin
      check("model key_pulse",  bus.key_pulse,  m_pulse);
      check("model dir",        bus.dir,        m_dir);
      check("model dir_change", bus.dir_change, m_chg);
      check("model q_level",    bus.q_level,    m_q.size());
      check("model q_overflow", bus.q_overflow, m_ovf);
    end
    if (bus.q_overflow === 1'b1) ovf_cnt++;
    if (bus.dir_change === 1'b1) chg_cnt++;
    for (int k = 0; k < NK; k++)
      if (bus.key_pulse[k] === 1'b1) begin pcnt[k]++; plast[k] = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic press(input int k);
    bus.key_in[k] = 1'b0;
    repeat (LAT + 3) tick();
    bus.key_in[k] = 1'b1;
    repeat (LAT + 3) tick();
  endtask

  task automatic do_step();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    repeat (3) tick();
  endtask

  typedef struct {
    bit rst;
    int key;
    bit stp;
    int lvl;
    int dirv;
    int ovf;
    int chg;
  } row_t;

  row_t tbl [20];

  initial begin
    int   t0, p0, o0, c0, w;
    int   hold [NK];
    dir_t exp_seq [4];

    for (int k = 0; k < NK; k++) begin pcnt[k] = 0; plast[k] = 0; hold[k] = 0; end
    bus.key_in = '1;
    bus.step   = 1'b0;
    rstn       = 1'b0;

    //               rst key stp lvl dir ovf chg
    tbl[0]  = '{1, -1, 0, 0, 2, 0, 0};
    tbl[1]  = '{0,  3, 0, 0, 2, 0, 0};  // left reverses right
    tbl[2]  = '{0,  0, 0, 1, 2, 0, 0};
    tbl[3]  = '{0, -1, 1, 0, 0, 0, 1};
    tbl[4]  = '{0, -1, 1, 0, 0, 0, 0};  // step on empty queue
    tbl[5]  = '{1, -1, 0, 0, 2, 0, 0};
    tbl[6]  = '{0,  0, 0, 1, 2, 0, 0};
    tbl[7]  = '{0,  2, 0, 2, 2, 0, 0};
    tbl[8]  = '{0,  1, 0, 3, 2, 0, 0};
    tbl[9]  = '{0,  3, 0, 4, 2, 0, 0};
    tbl[10] = '{0,  0, 0, 4, 2, 1, 0};  // fifth valid turn overflows
    tbl[11] = '{0, -1, 1, 3, 0, 0, 1};
    tbl[12] = '{0, -1, 1, 2, 2, 0, 1};
    tbl[13] = '{0, -1, 1, 1, 1, 0, 1};
    tbl[14] = '{0, -1, 1, 0, 3, 0, 1};
    tbl[15] = '{0, -1, 1, 0, 3, 0, 0};
    tbl[16] = '{0,  4, 0, 0, 3, 0, 0};  // pulse-only key
    tbl[17] = '{0,  2, 0, 0, 3, 0, 0};  // right reverses left
    tbl[18] = '{0,  3, 0, 0, 3, 0, 0};  // repeat
    tbl[19] = '{0,  0, 0, 1, 3, 0, 0};

    repeat (2) tick();
    check("reset q_level",    bus.q_level,    0);
    check("reset dir",        bus.dir,        2);
    check("reset key_pulse",  bus.key_pulse,  0);
    check("reset dir_change", bus.dir_change, 0);
    check("reset q_overflow", bus.q_overflow, 0);
    rstn = 1'b1;
    repeat (2) tick();

    for (int r = 0; r < 20; r++) begin
      o0 = ovf_cnt;
      c0 = chg_cnt;
      if (tbl[r].rst) do_reset();
      if (tbl[r].key >= 0) press(tbl[r].key);
      if (tbl[r].stp) do_step();
      check($sformatf("row%0d q_level", r), bus.q_level, tbl[r].lvl);
      check($sformatf("row%0d dir", r), bus.dir, tbl[r].dirv);
      check($sformatf("row%0d overflow", r), (ovf_cnt != o0) ? 1 : 0, tbl[r].ovf);
      check($sformatf("row%0d dir_change count", r), chg_cnt - c0, tbl[r].chg);
    end

    // Held key: one pulse, LAT cycles after the first pressed sample, none on release.
    do_reset();
    p0 = pcnt[0];
    t0 = cyc + 1;
    bus.key_in[0] = 1'b0;
    repeat (20) tick();
    check("hold pulse count", pcnt[0] - p0, 1);
    check("hold latency", plast[0] - t0, LAT);
    bus.key_in[0] = 1'b1;
    repeat (LAT + 3) tick();
    check("release no pulse", pcnt[0] - p0, 1);

    // Bounce: 5 low, 1 high, then low; only the final low run counts.
    do_reset();
    p0 = pcnt[2];
    bus.key_in[2] = 1'b0;
    repeat (5) tick();
    bus.key_in[2] = 1'b1;
    tick();
    bus.key_in[2] = 1'b0;
    t0 = cyc + 1;
    repeat (LAT - 1) tick();
    check("bounce no early pulse", pcnt[2] - p0, 0);
    repeat (5) tick();
    check("bounce pulse count", pcnt[2] - p0, 1);
    check("bounce latency", plast[2] - t0, LAT);
    bus.key_in[2] = 1'b1;
    repeat (LAT + 3) tick();

    // Full queue with a valid press landing in the same cycle as step.
    do_reset();
    press(0); press(2); press(1); press(3);
    check("full q_level", bus.q_level, 4);
    o0 = ovf_cnt;
    bus.key_in[0] = 1'b0;
    w = 0;
    while (bus.key_pulse[0] !== 1'b1 && w < LAT + 6) begin tick(); w++; end
    check("coincident pulse seen", bus.key_pulse[0], 1);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.key_in[0] = 1'b1;
    repeat (3) tick();
    check("push+pop q_level", bus.q_level, 4);
    check("push+pop no overflow", (ovf_cnt != o0) ? 1 : 0, 0);
    check("push+pop dir", bus.dir, 0);
    exp_seq[0] = DIR_RIGHT; exp_seq[1] = DIR_DOWN; exp_seq[2] = DIR_LEFT; exp_seq[3] = DIR_UP;
    for (int i = 0; i < 4; i++) begin
      do_step();
      check($sformatf("fifo order %0d", i), bus.dir, exp_seq[i]);
    end
    repeat (LAT) tick();

    // Reset with 3 queued and key 1 mid-debounce; key stays held through reset.
    do_reset();
    press(0); press(2); press(1);
    check("pre-reset q_level", bus.q_level, 3);
    bus.key_in[1] = 1'b0;
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    check("mid reset q_level",    bus.q_level,    0);
    check("mid reset dir",        bus.dir,        2);
    check("mid reset key_pulse",  bus.key_pulse,  0);
    check("mid reset dir_change", bus.dir_change, 0);
    check("mid reset q_overflow", bus.q_overflow, 0);
    p0 = pcnt[1];
    t0 = cyc + 1;
    rstn = 1'b1;
    repeat (LAT + 4) tick();
    check("held-through-reset pulse count", pcnt[1] - p0, 1);
    check("held-through-reset latency", plast[1] - t0, LAT);
    check("held-through-reset q_level", bus.q_level, 1);
    bus.key_in[1] = 1'b1;
    repeat (LAT + 3) tick();

    // Random traffic; the negedge model compares every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          bus.key_in[k] = 1'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 24);
        end else begin
          hold[k]--;
        end
      end
      bus.step = ($urandom_range(0, 3) == 0);
      rstn = ($urandom_range(0, 399) != 0);
      tick();
    end
    rstn = 1'b1;
    bus.step = 1'b0;
    bus.key_in = '1;
    repeat (LAT + 4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
